// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP layer sequencer.
// Holds the counter and layer widths, the FSM state encoding and the phase-length
// helpers. The phase lengths depend only on the systolic array dimension.
package mlp_pkg;

    localparam int unsigned CNT_W   = 5;
    localparam int unsigned LAYER_W = 3;

    typedef enum logic [3:0] {
        StIdle        = 4'd0,
        StLoadWeight  = 4'd1,
        StLoadAct     = 4'd2,
        StCompute     = 4'd3,
        StDrain       = 4'd4,
        StTransfer    = 4'd5,
        StNextLayer   = 4'd6,
        StWaitWeights = 4'd7,
        StDone        = 4'd8
    } mlp_state_e;

    // Phase lengths in cycles, as a function of the array dimension.
    function automatic int unsigned load_len(input int unsigned array_n);
        return array_n + 1;
    endfunction

    function automatic int unsigned act_len(input int unsigned array_n);
        return array_n + 2;
    endfunction

    function automatic int unsigned compute_len(input int unsigned array_n);
        return array_n + 1;
    endfunction

    function automatic int unsigned drain_len(input int unsigned array_n);
        return 3 * array_n + 1;
    endfunction

    function automatic int unsigned transfer_len(input int unsigned array_n);
        return array_n + 2;
    endfunction

    // Counter value seen in the final cycle of a phase of the given length.
    function automatic logic [CNT_W-1:0] last_cnt(input int unsigned len);
        return CNT_W'(len - 1);
    endfunction

endpackage

// File: rtl/mlp_phase_decode.sv
// Combinational decode of sequencer state and in-state cycle count into strobes.
// Ports:
//   state_i       current FSM state
//   cnt_i         cycle count within the current state
//   wf_pop_o      weight FIFO pop / pass-through enable
//   capture_col_o one-hot per-column weight capture strobe
//   ub_rd_ready_o activation UB read enable
//   mmu_valid_o   MMU output valid
//   refill_en_o   activation results may be written back to the UB
//   layer_done_o  last DRAIN cycle of a layer
//   done_o        pass complete
//   busy_o        state is not IDLE
module mlp_phase_decode
    import mlp_pkg::*;
#(
    parameter int unsigned ARRAY_N = 2
) (
    input  mlp_state_e         state_i,
    input  logic [CNT_W-1:0]   cnt_i,
    output logic               wf_pop_o,
    output logic [ARRAY_N-1:0] capture_col_o,
    output logic               ub_rd_ready_o,
    output logic               mmu_valid_o,
    output logic               refill_en_o,
    output logic               layer_done_o,
    output logic               done_o,
    output logic               busy_o
);

    localparam logic [CNT_W-1:0] DrainLast = last_cnt(drain_len(ARRAY_N));
    localparam logic [CNT_W-1:0] MmuFirst  = CNT_W'(ARRAY_N);

    always_comb begin
        capture_col_o = '0;
        if (state_i == StLoadWeight) begin
            // Column k latches its weights one cycle after the k-th pop.
            for (int k = 0; k < int'(ARRAY_N); k++) begin
                capture_col_o[k] = (cnt_i == CNT_W'(k + 1));
            end
        end
    end

    always_comb begin
        wf_pop_o      = (state_i == StLoadWeight);
        ub_rd_ready_o = (state_i == StCompute);
        // Results start leaving the array once the skewed wavefront has crossed it.
        mmu_valid_o   = ((state_i == StCompute) && (cnt_i >= MmuFirst)) ||
                        (state_i == StDrain);
        refill_en_o   = (state_i == StDrain) || (state_i == StTransfer);
        layer_done_o  = (state_i == StDrain) && (cnt_i == DrainLast);
        done_o        = (state_i == StDone);
        busy_o        = (state_i != StIdle);
    end

endmodule

// File: rtl/mlp_sequencer.sv
// Layer sequencer for a systolic-array MLP engine.
// Steps each layer through weight load, activation load (first layer only), compute,
// drain and result transfer, ping-ponging the unified buffers between layers.
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   start           run request, sampled only in IDLE
//   num_layers      layer count, captured on an accepted start
//   weights_ready   next layer's weights are available
//   abort           return to IDLE from any busy state
//   state           current state encoding
//   cycle_cnt       cycle count within the current state
//   current_layer   active layer index
//   buffer_select   UB ping-pong select
//   wf_pop .. busy  decoded strobes (see mlp_phase_decode)
//   accum_en        registered accumulate enable
//   cfg_err         sticky illegal-layer-count flag
module mlp_sequencer
    import mlp_pkg::*;
#(
    parameter int unsigned ARRAY_N    = 2,
    parameter int unsigned MAX_LAYERS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [LAYER_W:0]   num_layers,
    input  logic               weights_ready,
    input  logic               abort,
    output logic [3:0]         state,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [LAYER_W-1:0] current_layer,
    output logic               buffer_select,
    output logic               wf_pop,
    output logic [ARRAY_N-1:0] capture_col,
    output logic               ub_rd_ready,
    output logic               mmu_valid,
    output logic               accum_en,
    output logic               refill_en,
    output logic               layer_done,
    output logic               done,
    output logic               busy,
    output logic               cfg_err
);

    localparam int unsigned NL_W = LAYER_W + 1;

    localparam logic [CNT_W-1:0] LoadLast     = last_cnt(load_len(ARRAY_N));
    localparam logic [CNT_W-1:0] ActLast      = last_cnt(act_len(ARRAY_N));
    localparam logic [CNT_W-1:0] ComputeLast  = last_cnt(compute_len(ARRAY_N));
    localparam logic [CNT_W-1:0] DrainLast    = last_cnt(drain_len(ARRAY_N));
    localparam logic [CNT_W-1:0] TransferLast = last_cnt(transfer_len(ARRAY_N));
    localparam logic [CNT_W-1:0] CntMax       = '1;

    mlp_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [NL_W-1:0]    num_layers_q, num_layers_d;
    logic               buf_q, buf_d;
    logic               accum_q, accum_d;
    logic               cfg_err_q, cfg_err_d;

    logic start_legal;
    logic more_layers;

    assign start_legal = (num_layers != '0) && (num_layers <= NL_W'(MAX_LAYERS));
    // Written as layer+1 < N so an unlatched count of zero cannot underflow.
    assign more_layers = (({1'b0, layer_q} + NL_W'(1)) < num_layers_q);

    always_comb begin
        state_d      = state_q;
        layer_d      = layer_q;
        num_layers_d = num_layers_q;
        buf_d        = buf_q;
        accum_d      = accum_q;
        cfg_err_d    = cfg_err_q;

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            accum_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (start_legal) begin
                            state_d      = StLoadWeight;
                            num_layers_d = num_layers;
                            layer_d      = '0;
                            buf_d        = 1'b0;
                            cfg_err_d    = 1'b0;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                StLoadWeight: begin
                    if (cnt_q == LoadLast) begin
                        // Later layers already have activations in the UB.
                        state_d = (layer_q == '0) ? StLoadAct : StCompute;
                    end
                end
                StLoadAct: begin
                    if (cnt_q == ActLast) state_d = StCompute;
                end
                StCompute: begin
                    if (cnt_q == ComputeLast) begin
                        state_d = StDrain;
                        accum_d = 1'b1;
                    end
                end
                StDrain: begin
                    if (cnt_q == DrainLast) state_d = more_layers ? StTransfer : StDone;
                end
                StTransfer: begin
                    if (cnt_q == TransferLast) state_d = StNextLayer;
                end
                StNextLayer: begin
                    state_d = StWaitWeights;
                    buf_d   = ~buf_q;
                    layer_d = layer_q + LAYER_W'(1);
                    accum_d = 1'b0;
                end
                StWaitWeights: begin
                    if (weights_ready) state_d = StLoadWeight;
                end
                StDone: begin
                    state_d = StIdle;
                    accum_d = 1'b0;
                end
                default: begin
                    state_d = StIdle;
                    accum_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == StWaitWeights) && (cnt_q == CntMax)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            layer_q      <= '0;
            num_layers_q <= '0;
            buf_q        <= 1'b0;
            accum_q      <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            layer_q      <= layer_d;
            num_layers_q <= num_layers_d;
            buf_q        <= buf_d;
            accum_q      <= accum_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    mlp_phase_decode #(
        .ARRAY_N(ARRAY_N)
    ) u_decode (
        .state_i      (state_q),
        .cnt_i        (cnt_q),
        .wf_pop_o     (wf_pop),
        .capture_col_o(capture_col),
        .ub_rd_ready_o(ub_rd_ready),
        .mmu_valid_o  (mmu_valid),
        .refill_en_o  (refill_en),
        .layer_done_o (layer_done),
        .done_o       (done),
        .busy_o       (busy)
    );

    assign state         = state_q;
    assign cycle_cnt     = cnt_q;
    assign current_layer = layer_q;
    assign buffer_select = buf_q;
    assign accum_en      = accum_q;
    assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_mlp_sequencer.sv
// Directed bench for mlp_sequencer: an ARRAY_N=2 instance for the main scenarios
// and an ARRAY_N=4 instance for the phase-length scaling check.
module tb_mlp_sequencer;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // ARRAY_N = 2 instance
    logic       start, weights_ready, abort;
    logic [3:0] num_layers;
    logic [3:0] state;
    logic [4:0] cycle_cnt;
    logic [2:0] current_layer;
    logic       buffer_select, wf_pop, ub_rd_ready, mmu_valid, accum_en;
    logic       refill_en, layer_done, done, busy, cfg_err;
    logic [1:0] capture_col;

    mlp_sequencer #(
        .ARRAY_N   (2),
        .MAX_LAYERS(4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .num_layers   (num_layers),
        .weights_ready(weights_ready),
        .abort        (abort),
        .state        (state),
        .cycle_cnt    (cycle_cnt),
        .current_layer(current_layer),
        .buffer_select(buffer_select),
        .wf_pop       (wf_pop),
        .capture_col  (capture_col),
        .ub_rd_ready  (ub_rd_ready),
        .mmu_valid    (mmu_valid),
        .accum_en     (accum_en),
        .refill_en    (refill_en),
        .layer_done   (layer_done),
        .done         (done),
        .busy         (busy),
        .cfg_err      (cfg_err)
    );

    // ARRAY_N = 4 instance
    logic       start4, weights_ready4, abort4;
    logic [3:0] num_layers4;
    logic [3:0] state4;
    logic [4:0] cycle_cnt4;
    logic [2:0] current_layer4;
    logic       buffer_select4, wf_pop4, ub_rd_ready4, mmu_valid4, accum_en4;
    logic       refill_en4, layer_done4, done4, busy4, cfg_err4;
    logic [3:0] capture_col4;

    mlp_sequencer #(
        .ARRAY_N   (4),
        .MAX_LAYERS(4)
    ) dut4 (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start4),
        .num_layers   (num_layers4),
        .weights_ready(weights_ready4),
        .abort        (abort4),
        .state        (state4),
        .cycle_cnt    (cycle_cnt4),
        .current_layer(current_layer4),
        .buffer_select(buffer_select4),
        .wf_pop       (wf_pop4),
        .capture_col  (capture_col4),
        .ub_rd_ready  (ub_rd_ready4),
        .mmu_valid    (mmu_valid4),
        .accum_en     (accum_en4),
        .refill_en    (refill_en4),
        .layer_done   (layer_done4),
        .done         (done4),
        .busy         (busy4),
        .cfg_err      (cfg_err4)
    );

    int tests = 0;
    int fails = 0;

    // Statistics gathered by run2
    int         cyc, ld_cnt, act_cnt, done_cnt;
    logic [1:0] cap1, cap2;
    logic [2:0] bs_hist;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a pass on the ARRAY_N=2 instance and follow it until done (bounded).
    // weights_ready rises once WAIT_WEIGHTS has lasted 5 cycles.
    task automatic run2(input logic [3:0] nl, input int limit);
        start = 1'b1;
        num_layers = nl;
        tick();
        start = 1'b0;
        cyc = 0; ld_cnt = 0; act_cnt = 0; done_cnt = 0;
        cap1 = 2'bxx; cap2 = 2'bxx; bs_hist = 3'bxxx;
        for (int i = 0; i < limit; i++) begin
            if (state == 4'd1 && current_layer == 3'd0 && cycle_cnt == 5'd1) cap1 = capture_col;
            if (state == 4'd1 && current_layer == 3'd0 && cycle_cnt == 5'd2) cap2 = capture_col;
            if (state == 4'd2 && cycle_cnt == 5'd0) act_cnt++;
            if (layer_done) begin
                if (ld_cnt < 3) bs_hist[ld_cnt] = buffer_select;
                ld_cnt++;
            end
            weights_ready = (state == 4'd7) && (cycle_cnt >= 5'd4);
            if (done) begin
                done_cnt++;
                break;
            end
            tick();
            cyc++;
        end
        weights_ready = 1'b0;
    endtask

    initial begin : main
        int   lw4, cmp4, dr4, c4;
        logic mmu_seen;
        logic [3:0] mmu_state;
        logic [4:0] mmu_cnt;
        logic seen_done;

        reset_n = 1'b0;
        start = 1'b0; num_layers = '0; weights_ready = 1'b0; abort = 1'b0;
        start4 = 1'b0; num_layers4 = '0; weights_ready4 = 1'b0; abort4 = 1'b0;

        // Reset state
        #2;
        check("reset_state", 32'(state), 32'd0);
        check("reset_cnt", 32'(cycle_cnt), 32'd0);
        check("reset_layer_buf", 32'({current_layer, buffer_select}), 32'd0);
        check("reset_strobes", 32'({wf_pop, capture_col, ub_rd_ready, mmu_valid, refill_en,
                                    layer_done, done, busy, accum_en, cfg_err}), 32'd0);
        check("reset_state4", 32'({state4, busy4}), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Single layer, ARRAY_N=2: done 17 cycles after the start edge
        run2(4'd1, 40);
        check("l1_done_latency", 32'(cyc), 32'd17);
        check("l1_capture_cnt1", 32'(cap1), 32'b01);
        check("l1_capture_cnt2", 32'(cap2), 32'b10);
        check("l1_layer_done_count", 32'(ld_cnt), 32'd1);
        check("l1_act_entries", 32'(act_cnt), 32'd1);
        tick();
        check("l1_back_idle", 32'({state, done, busy}), 32'd0);

        // Three layers with delayed weights
        run2(4'd3, 120);
        check("l3_done_latency", 32'(cyc), 32'd63);
        check("l3_layer_done_count", 32'(ld_cnt), 32'd3);
        check("l3_buffer_sequence", 32'(bs_hist), 32'b010);
        check("l3_act_entries", 32'(act_cnt), 32'd1);
        check("l3_done_count", 32'(done_cnt), 32'd1);
        tick();

        // Illegal layer counts, then a legal start
        start = 1'b1; num_layers = 4'd0;
        tick();
        start = 1'b0;
        check("cfg_zero_err", 32'({state, cfg_err}), 32'h01);
        start = 1'b1; num_layers = 4'd5;
        tick();
        start = 1'b0;
        check("cfg_five_err", 32'({state, cfg_err}), 32'h01);
        run2(4'd1, 40);
        check("cfg_cleared", 32'(cfg_err), 32'd0);
        check("cfg_run_latency", 32'(cyc), 32'd17);
        tick();

        // Abort in DRAIN cnt 3
        start = 1'b1; num_layers = 4'd1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (state == 4'd4 && cycle_cnt == 5'd3) break;
            tick();
        end
        check("abort_reached_drain3", 32'({state, cycle_cnt}), 32'({4'd4, 5'd3}));
        check("abort_accum_before", 32'({accum_en, mmu_valid, refill_en}), 32'b111);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", 32'({state, busy}), 32'd0);
        check("abort_accum_after", 32'({accum_en, done}), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen_done |= done;
            tick();
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        run2(4'd1, 40);
        check("abort_rerun_latency", 32'(cyc), 32'd17);
        tick();

        // Start ignored while busy; WAIT_WEIGHTS saturation; abort beats weights_ready
        start = 1'b1; num_layers = 4'd2;
        tick();
        num_layers = 4'd0;
        tick();
        start = 1'b0;
        check("busy_start_ignored", 32'({state, cycle_cnt, cfg_err}), 32'({4'd1, 5'd1, 1'b0}));
        for (int i = 0; i < 60; i++) begin
            if (state == 4'd7) break;
            tick();
        end
        check("wait_entered", 32'({state, current_layer, buffer_select}),
              32'({4'd7, 3'd1, 1'b1}));
        for (int i = 0; i < 40; i++) tick();
        check("wait_saturated", 32'({state, cycle_cnt}), 32'({4'd7, 5'd31}));
        weights_ready = 1'b1; abort = 1'b1;
        tick();
        weights_ready = 1'b0; abort = 1'b0;
        check("abort_priority", 32'({state, busy}), 32'd0);
        tick();

        // Asynchronous reset during layer 1 COMPUTE
        start = 1'b1; num_layers = 4'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            weights_ready = (state == 4'd7);
            if (state == 4'd3 && current_layer == 3'd1) break;
            tick();
        end
        weights_ready = 1'b0;
        check("rst_pre_compute", 32'({state, current_layer, buffer_select, ub_rd_ready}),
              32'({4'd3, 3'd1, 1'b1, 1'b1}));
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_state", 32'({state, cycle_cnt, current_layer, buffer_select}), 32'd0);
        check("rst_async_strobes", 32'({wf_pop, capture_col, ub_rd_ready, mmu_valid, refill_en,
                                        layer_done, done, busy, accum_en, cfg_err}), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // ARRAY_N=4 phase lengths
        lw4 = 0; cmp4 = 0; dr4 = 0; c4 = 0;
        mmu_seen = 1'b0; mmu_state = 4'hf; mmu_cnt = 5'h1f;
        start4 = 1'b1; num_layers4 = 4'd1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (state4 == 4'd1) lw4++;
            if (state4 == 4'd3) cmp4++;
            if (state4 == 4'd4) dr4++;
            if (mmu_valid4 && !mmu_seen) begin
                mmu_seen = 1'b1;
                mmu_state = state4;
                mmu_cnt = cycle_cnt4;
            end
            if (done4) break;
            tick();
            c4++;
        end
        check("n4_load_weight_len", 32'(lw4), 32'd5);
        check("n4_compute_len", 32'(cmp4), 32'd5);
        check("n4_drain_len", 32'(dr4), 32'd13);
        check("n4_mmu_first", 32'({mmu_state, mmu_cnt}), 32'({4'd3, 5'd4}));
        check("n4_done_latency", 32'(c4), 32'd29);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
